long_multiply: RTL and testbench

LONG_MULTIPLY -- requirements
Module: long_multiply

---
 rtl/long_multiply.sv | 124 ++++++++++++
 tb/tb_long_multiply.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/long_multiply.sv
// Unsigned shift-add multiply-accumulate: computes a*b+c into a 2*WIDTH-bit result,
// LSB-first, one multiplier bit per clock, with a fixed latency of WIDTH cycles.
module long_multiply #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     a1_q, a1_d;
  logic [IW-1:0]        i_q, i_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0]     prod_lo_q, prod_lo_d;

  // One shift-add step: the add is WIDTH+1 bits wide so its carry shifts into P's top bit.
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_step;

  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a1_q : {WIDTH{1'b0}})};
    p_step = {sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    a1_d      = a1_q;
    i_d       = i_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;

    // start wins over everything, including the final iteration of a running job.
    if (start) begin
      state_d = S_RUN;
      p_d     = {c, b};
      a1_d    = a;
      i_d     = '0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          p_d = p_step;
          if (i_q == I_LAST) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            valid_d   = 1'b1;
            prod_hi_d = p_step[2*WIDTH-1:WIDTH];
            prod_lo_d = p_step[WIDTH-1:0];
            ovf_d     = |p_step[2*WIDTH-1:WIDTH];
          end else begin
            i_d = i_q + IW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      a1_q      <= '0;
      i_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      a1_q      <= a1_d;
      i_q       <= i_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;
  assign ovf     = ovf_q;
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_long_multiply.sv
// Directed and randomised bench for long_multiply: results, latency, restart and reset behaviour.
module tb_long_multiply;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy, done, valid, ovf;
  logic [W-1:0] a, b, c;
  logic [W-1:0] prod_hi, prod_lo;

  long_multiply #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .ovf     (ovf),
    .a       (a),
    .b       (b),
    .c       (c),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Expected {prod_hi, prod_lo, ovf} and the cycle number at which done must appear.
  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] pack(input int hi, input int lo, input int ov);
    pack = {hi[W-1:0], lo[W-1:0], ov[0]};
  endfunction

  function automatic logic [2*W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic [W-1:0] tc);
    logic [2*W-1:0] r;
    r = (2*W)'(ta) * (2*W)'(tb) + (2*W)'(tc);
    model = {r, |r[2*W-1:W]};
  endfunction

  // Drive one start; operands are scrambled right after the start edge.
  task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                          input bit track, input logic [2*W:0] e);
    @(negedge clk);
    a = ta; b = tb; c = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom_range(0, 31));
    b = W'($urandom_range(0, 31));
    c = W'($urandom_range(0, 31));
    check("busy_after_start", busy, 1);
    check("valid_cleared_at_start", valid, 0);
    if (track) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + W);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = done_cnt;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (done_cnt != n) break;
    end
    check("done_seen", done_cnt, n + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_hi"}, prod_hi, 0);
    check({tag, "_lo"}, prod_lo, 0);
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(posedge clk) begin
    logic [2*W:0] e;
    int           ec;
    #1;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("prod_hi", prod_hi, e[2*W:W+1]);
        check("prod_lo", prod_lo, e[W:1]);
        check("ovf", ovf, e[0]);
        check("valid_at_done", valid, 1);
        check("busy_at_done", busy, 0);
        check("latency", cyc, ec);
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb, rc;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    do_start(5'd3, 5'd4, 5'd5, 1'b1, pack(0, 17, 0));
    wait_done(W + 3);
    @(posedge clk);
    #2;
    check("done_one_cycle", done, 0);
    check("valid_holds", valid, 1);
    check("busy_idle", busy, 0);

    do_start(5'd7, 5'd6, 5'd0, 1'b1, pack(1, 10, 1));
    @(posedge clk);
    #2;
    check("hold_lo_mid_run", prod_lo, 17);
    check("hold_hi_mid_run", prod_hi, 0);
    check("hold_ovf_mid_run", ovf, 0);
    wait_done(W + 3);

    do_start(5'd31, 5'd31, 5'd31, 1'b1, pack(31, 0, 1));
    wait_done(W + 3);

    do_start(5'd13, 5'd0, 5'd9, 1'b1, pack(0, 9, 0));
    wait_done(W + 3);

    // Restart two cycles into a calculation.
    n = done_cnt;
    do_start(5'd2, 5'd3, 5'd0, 1'b0, '0);
    @(posedge clk);
    do_start(5'd5, 5'd5, 5'd1, 1'b1, pack(0, 26, 0));
    wait_done(W + 3);
    repeat (3) @(posedge clk);
    #2;
    check("restart_single_done", done_cnt, n + 1);

    // Restart exactly on the final iteration edge.
    n = done_cnt;
    do_start(5'd1, 5'd2, 5'd3, 1'b0, '0);
    repeat (W - 1) @(posedge clk);
    do_start(5'd6, 5'd7, 5'd8, 1'b1, pack(1, 18, 1));
    wait_done(W + 3);
    repeat (3) @(posedge clk);
    #2;
    check("final_edge_restart_single_done", done_cnt, n + 1);

    for (int k = 0; k < 4; k++) begin
      ra = W'($urandom_range(0, 31));
      rb = W'($urandom_range(0, 31));
      rc = W'($urandom_range(0, 31));
      do_start(ra, rb, rc, 1'b1, model(ra, rb, rc));
      wait_done(W + 3);
    end

    // Asynchronous reset three cycles into a calculation.
    n = done_cnt;
    do_start(5'd9, 5'd9, 5'd9, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("reset_no_done", done_cnt, n);
    do_start(5'd1, 5'd1, 5'd1, 1'b1, pack(0, 2, 0));
    wait_done(W + 3);
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
